// File: rtl/sdram_pattern_checker_if.sv
// Two-FIFO user-side bus between the pattern checker (master) and the SDRAM controller top (slave).
interface sdram_pattern_checker_if #(
   parameter int DATA_W = 16
);
   logic              sdram_init_done;
   logic              wr_load;
   logic              rd_load;
   logic              sys_we;
   logic [DATA_W-1:0] sys_data_in;
   logic              sys_rd;
   logic [DATA_W-1:0] sys_data_out;

   modport master (
      input  sdram_init_done,
      input  sys_data_out,
      output wr_load,
      output rd_load,
      output sys_we,
      output sys_data_in,
      output sys_rd
   );

   modport slave (
      output sdram_init_done,
      output sys_data_out,
      input  wr_load,
      input  rd_load,
      input  sys_we,
      input  sys_data_in,
      input  sys_rd
   );
endinterface

// File: rtl/sdram_pattern_checker.sv
// Writes LEN pattern words into the SDRAM write FIFO, reads them back and checks them.
// Optional feature macro: SDRAM_CHK_ERR_INJECT_EN (corrupts bit 0 of word 0 of every pass).
module sdram_pattern_checker #(
   parameter int DATA_W     = 16,
   parameter int LEN        = 512,
   parameter int RD_LAT     = 1,
   parameter int GAP_CYCLES = 64,
   parameter int ERR_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic                   loop_en,
   input  logic                   err_inject,
   sdram_pattern_checker_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [ERR_W-1:0]       err_cnt,
   output logic [15:0]            pass_cnt,
   output logic [15:0]            first_err_idx,
   output logic [DATA_W-1:0]      first_err_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_INIT, S_LOAD, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LEN_LAST  = 16'(LEN - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] RD_LAST   = 16'(RD_LAT - 1);

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Word k of the selected pattern; the LFSR state for word k is carried by the caller.
   function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0] m, input logic [15:0] k,
                                                      input logic [15:0] lfsr);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int i = 0; i < DATA_W; i++) begin
         case (m)
            2'd0:    w[i] = (i < 16) ? k[i % 16] : 1'b0;
            2'd1:    w[i] = lfsr[i % 16];
            2'd2:    w[i] = ((int'(k) % DATA_W) == i);
            default: w[i] = ((i % 2) == 0) ? ~k[0] : k[0];
         endcase
      end
      return w;
   endfunction

   state_t            state, next_state;
   logic [15:0]       cnt;
   logic [1:0]        mode_q;
   logic              load_q, we_q, rd_q;
   logic [DATA_W-1:0] data_in_q;
   logic [15:0]       wr_idx, wr_lfsr, rd_idx, rd_lfsr;
   logic [RD_LAT-1:0] rd_pipe;
   logic              rd_valid;
   logic [DATA_W-1:0] wr_word, exp_word;

`ifdef SDRAM_CHK_ERR_INJECT_EN
   logic inj_armed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         inj_armed <= 1'b0;
      else if (state == S_IDLE && start)
         inj_armed <= err_inject;
   end
`else
   logic unused_inject;
   assign unused_inject = err_inject;
`endif

   assign bus.wr_load     = load_q;
   assign bus.rd_load     = load_q;
   assign bus.sys_we      = we_q;
   assign bus.sys_rd      = rd_q;
   assign bus.sys_data_in = data_in_q;
   assign rd_valid        = rd_pipe[RD_LAT-1];
   assign exp_word        = pattern_word(mode_q, rd_idx, rd_lfsr);

   always_comb begin
      wr_word = pattern_word(mode_q, wr_idx, wr_lfsr);
`ifdef SDRAM_CHK_ERR_INJECT_EN
      if (inj_armed && wr_idx == 16'd0)
         wr_word[0] = ~wr_word[0];
`endif
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (start) next_state = S_WAIT_INIT;
         S_WAIT_INIT: if (bus.sdram_init_done) next_state = S_LOAD;
         S_LOAD:      next_state = S_WRITE;
         S_WRITE:     if (cnt == LEN_LAST) next_state = (GAP_CYCLES == 0) ? S_READ : S_GAP;
         S_GAP:       if (cnt == GAP_LAST) next_state = S_READ;
         S_READ:      if (cnt == LEN_LAST) next_state = S_DRAIN;
         S_DRAIN:     if (cnt == RD_LAST) next_state = S_DONE;
         S_DONE:      next_state = loop_en ? S_LOAD : S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   // Outputs are registered from next_state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         mode_q    <= '0;
         load_q    <= 1'b1;
         we_q      <= 1'b0;
         rd_q      <= 1'b0;
         data_in_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state  <= next_state;
         cnt    <= (next_state != state) ? 16'd0 : cnt + 16'd1;
         load_q <= (next_state == S_IDLE) || (next_state == S_WAIT_INIT) || (next_state == S_LOAD);
         we_q   <= (next_state == S_WRITE);
         rd_q   <= (next_state == S_READ);
         busy   <= (next_state != S_IDLE);
         done   <= (next_state == S_DONE);
         if (state == S_IDLE && start)
            mode_q <= mode;
         if (next_state == S_WRITE)
            data_in_q <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx  <= '0;
         wr_lfsr <= LFSR_SEED;
      end else if (next_state == S_WRITE) begin
         wr_idx  <= wr_idx + 16'd1;
         wr_lfsr <= lfsr_next(wr_lfsr);
      end else begin
         wr_idx  <= '0;
         wr_lfsr <= LFSR_SEED;
      end
   end

   // rd_pipe tracks sys_rd through the FIFO read latency; its last stage marks a valid beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe        <= '0;
         rd_idx         <= '0;
         rd_lfsr        <= LFSR_SEED;
         fail           <= 1'b0;
         err_cnt        <= '0;
         pass_cnt       <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else begin
         rd_pipe[0] <= rd_q;
         for (int i = 1; i < RD_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
         if (state == S_IDLE && start) begin
            fail           <= 1'b0;
            err_cnt        <= '0;
            pass_cnt       <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
         end else begin
            if (state == S_LOAD) begin
               rd_idx  <= '0;
               rd_lfsr <= LFSR_SEED;
            end else if (rd_valid) begin
               rd_idx  <= rd_idx + 16'd1;
               rd_lfsr <= lfsr_next(rd_lfsr);
               if (bus.sys_data_out != exp_word) begin
                  if (err_cnt != {ERR_W{1'b1}})
                     err_cnt <= err_cnt + ERR_W'(1);
                  fail <= 1'b1;
                  if (!fail) begin
                     first_err_idx  <= rd_idx;
                     first_err_data <= bus.sys_data_out;
                  end
               end
            end
            if (next_state == S_DONE)
               pass_cnt <= pass_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Scoreboard bench for sdram_pattern_checker: a FIFO model answers reads, a forked monitor checks
// every written word and every end-of-pass result against expectations queued by the stimulus.
module tb_sdram_pattern_checker;

   localparam int DATA_W   = 16;
   localparam int LEN      = 512;
   localparam int RD_LAT   = 1;
   localparam int GAP      = 64;
   localparam int PASS_CYC = 1 + LEN + GAP + LEN + RD_LAT + 1;

   typedef struct {
      int          cyc;
      logic        fail;
      logic [15:0] err;
      logic [15:0] pcnt;
      logic [15:0] idx;
      logic [15:0] data;
   } pass_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic        loop_en;
   logic        err_inject;
   logic        busy, done, fail;
   logic [15:0] err_cnt, pass_cnt, first_err_idx;
   logic [DATA_W-1:0] first_err_data;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int corrupt_idx = -1;
   int wr_ptr      = 0;
   int rd_ptr      = 0;
   logic [15:0] mem [0:LEN-1];

   logic [15:0] wr_q[$];
   pass_exp_t   pass_q[$];

   sdram_pattern_checker_if #(.DATA_W(DATA_W)) bus ();

   sdram_pattern_checker #(
      .DATA_W(DATA_W), .LEN(LEN), .RD_LAT(RD_LAT), .GAP_CYCLES(GAP), .ERR_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .mode(mode),
      .loop_en(loop_en),
      .err_inject(err_inject),
      .bus(bus),
      .busy(busy),
      .done(done),
      .fail(fail),
      .err_cnt(err_cnt),
      .pass_cnt(pass_cnt),
      .first_err_idx(first_err_idx),
      .first_err_data(first_err_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Ideal single-clock FIFO pair with one cycle of read latency and an optional corrupted word.
   always @(posedge clk) begin
      if (bus.wr_load)
         wr_ptr <= 0;
      else if (bus.sys_we) begin
         mem[wr_ptr % LEN] <= bus.sys_data_in;
         wr_ptr <= wr_ptr + 1;
      end
      if (bus.rd_load)
         rd_ptr <= 0;
      else if (bus.sys_rd) begin
         bus.sys_data_out <= (rd_ptr == corrupt_idx) ? 16'hDEAD : mem[rd_ptr % LEN];
         rd_ptr <= rd_ptr + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [15:0] modelWord(input logic [1:0] m, input int k, input logic [15:0] lfsr);
      case (m)
         2'd0:    return k[15:0];
         2'd1:    return lfsr;
         2'd2:    return 16'h0001 << (k % 16);
         default: return k[0] ? 16'hAAAA : 16'h5555;
      endcase
   endfunction

   task automatic pushWrites(input logic [1:0] m, input logic inj);
      logic [15:0] lfsr_hand [0:6];
      logic [15:0] lfsr;
      logic [15:0] w;
      lfsr_hand = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
      lfsr = 16'hACE1;
      for (int k = 0; k < LEN; k++) begin
         w = modelWord(m, k, lfsr);
         if (m == 2'd1 && k < 7)
            w = lfsr_hand[k];
`ifdef SDRAM_CHK_ERR_INJECT_EN
         if (inj && k == 0)
            w = w ^ 16'h0001;
`else
         if (inj && k < 0)
            w = 16'h0000;
`endif
         wr_q.push_back(w);
         lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      end
   endtask

   task automatic monitorLoop();
      pass_exp_t p;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.sys_we) begin
               if (wr_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_write: got data %0h, expected no write", bus.sys_data_in);
               end else
                  checkOutput("sys_data_in", 32'(bus.sys_data_in), 32'(wr_q.pop_front()));
            end
            if (done) begin
               if (pass_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
               end else begin
                  p = pass_q.pop_front();
                  checkOutput("done_cycle", cyc, p.cyc);
                  checkOutput("fail", 32'(fail), 32'(p.fail));
                  checkOutput("err_cnt", 32'(err_cnt), 32'(p.err));
                  checkOutput("pass_cnt", 32'(pass_cnt), 32'(p.pcnt));
                  checkOutput("first_err_idx", 32'(first_err_idx), 32'(p.idx));
                  checkOutput("first_err_data", 32'(first_err_data), 32'(p.data));
               end
            end
         end
      end
   endtask

   // Queue expectations for a run and pulse start; init_delay > 0 holds init low that many cycles.
   task automatic applyStimulus(input logic [1:0] m, input logic lp, input logic inj, input int passes,
                                input int corrupt, input int init_delay);
      pass_exp_t p;
      int   n0, first_done, e_per_pass;
      logic ok;
      logic [15:0] e_idx, e_data;
      e_per_pass = 0;
      e_idx      = 16'h0;
      e_data     = 16'h0;
      if (corrupt >= 0) begin
         e_per_pass = 1;
         e_idx      = 16'(corrupt);
         e_data     = 16'hDEAD;
      end
`ifdef SDRAM_CHK_ERR_INJECT_EN
      if (inj) begin
         e_per_pass = 1;
         e_idx      = 16'h0;
         e_data     = modelWord(m, 0, 16'hACE1) ^ 16'h0001;
      end
`endif
      for (int i = 0; i < passes; i++) pushWrites(m, inj);
      corrupt_idx = corrupt;
      @(negedge clk);
      n0 = cyc;
      first_done = n0 + ((init_delay > 1) ? init_delay : 1) + PASS_CYC;
      for (int i = 0; i < passes; i++) begin
         p.cyc  = first_done + i * PASS_CYC;
         p.fail = (e_per_pass > 0);
         p.err  = 16'(e_per_pass * (i + 1));
         p.pcnt = 16'(i + 1);
         p.idx  = e_idx;
         p.data = e_data;
         pass_q.push_back(p);
      end
      if (init_delay > 0) bus.sdram_init_done = 1'b0;
      mode       = m;
      loop_en    = lp;
      err_inject = inj;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (init_delay > 0) begin
         ok = 1'b1;
         while (cyc < n0 + init_delay) begin
            if (!(bus.wr_load === 1'b1 && bus.sys_we === 1'b0)) ok = 1'b0;
            @(negedge clk);
         end
         checkOutput("wait_init_hold", 32'(ok), 32'd1);
         bus.sdram_init_done = 1'b1;
         @(negedge clk);
         checkOutput("wr_load_in_load", 32'(bus.wr_load), 32'd1);
         @(negedge clk);
         checkOutput("wr_load_in_write", 32'(bus.wr_load), 32'd0);
         checkOutput("rd_load_in_write", 32'(bus.rd_load), 32'd0);
         bus.sdram_init_done = 1'b0;
      end
   endtask

   task automatic waitDone(input string name, input int max_cycles);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s_timeout: got no done within %0d cycles, expected done", name, max_cycles);
      end
      @(negedge clk);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_wr_load"}, 32'(bus.wr_load), 32'd1);
      checkOutput({tag, "_rd_load"}, 32'(bus.rd_load), 32'd1);
      checkOutput({tag, "_sys_we"}, 32'(bus.sys_we), 32'd0);
      checkOutput({tag, "_sys_rd"}, 32'(bus.sys_rd), 32'd0);
      checkOutput({tag, "_sys_data_in"}, 32'(bus.sys_data_in), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_fail"}, 32'(fail), 32'd0);
      checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      checkOutput({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
      checkOutput({tag, "_first_err_idx"}, 32'(first_err_idx), 32'd0);
      checkOutput({tag, "_first_err_data"}, 32'(first_err_data), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      mode       = 2'd0;
      loop_en    = 1'b0;
      err_inject = 1'b0;
      bus.sdram_init_done = 1'b1;
      fork
         monitorLoop();
      join_none
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] mode 0 single pass, stray start while busy");
      applyStimulus(2'd0, 1'b0, 1'b0, 1, -1, 0);
      repeat (50) @(negedge clk);
      checkOutput("busy_mid_run", 32'(busy), 32'd1);
      mode  = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("mode0", 1300);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);

      $display("[TB] mode 1 LFSR pass");
      applyStimulus(2'd1, 1'b0, 1'b0, 1, -1, 0);
      waitDone("mode1", 1300);
      repeat (3) @(negedge clk);

      $display("[TB] mode 0 with read word 100 corrupted");
      applyStimulus(2'd0, 1'b0, 1'b0, 1, 100, 0);
      waitDone("corrupt", 1300);
      corrupt_idx = -1;
      repeat (3) @(negedge clk);

      $display("[TB] mode 0 with err_inject, two looped passes");
      applyStimulus(2'd0, 1'b1, 1'b1, 2, -1, 0);
      waitDone("inject_p1", 1300);
      loop_en    = 1'b0;
      err_inject = 1'b0;
      waitDone("inject_p2", 1300);
      repeat (3) @(negedge clk);

      $display("[TB] mode 2 with init held low for 200 cycles");
      applyStimulus(2'd2, 1'b0, 1'b0, 1, -1, 200);
      waitDone("init_delay", 1300);
      bus.sdram_init_done = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] mode 3 looping, reset during fourth pass read phase");
      applyStimulus(2'd3, 1'b1, 1'b0, 3, -1, 0);
      pushWrites(2'd3, 1'b0);
      waitDone("loop_p1", 1300);
      waitDone("loop_p2", 1300);
      waitDone("loop_p3", 1300);
      repeat (600) @(negedge clk);
      checkOutput("pass_cnt_before_reset", 32'(pass_cnt), 32'd3);
      checkOutput("sys_rd_before_reset", 32'(bus.sys_rd), 32'd1);
      rst = 1'b1;
      #1;
      checkResetValues("midrun");
      checkOutput("wr_queue_drained", wr_q.size(), 32'd0);
      checkOutput("pass_queue_drained", pass_q.size(), 32'd0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdram_pattern_checker.md
# sdram_pattern_checker

Parametrised self-checking traffic generator for the SDRAM two-FIFO user interface (`sys_we`/`sys_data_in`, `sys_rd`/`sys_data_out`, `wr_load`/`rd_load`, `sdram_init_done`). It writes a selectable data pattern of configurable length and width into the write FIFO, then reads the same number of words back. It compares every read word against a locally regenerated expected value and reports pass/fail, error count and first-failure details. It replaces fixed-length, debugger-only board tests and sits between the SDRAM controller top and board status logic (LEDs/UART).

## Interface
Parameters:
- `DATA_W`, 16: FIFO data width; legal values 8–32.
- `LEN`, 512: words per pass; legal values 2–65535.
- `RD_LAT`, 1: cycles from `sys_rd` high to valid `sys_data_out`; legal values 1–4.
- `GAP_CYCLES`, 64: idle cycles between the end of the write phase and the start of the read phase; legal values 0–1023.
- `ERR_W`, 16: width of the error counter.

Ports:
- `clk`, in, 1: single clock for all logic and both FIFO sides.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that starts a run; accepted only in IDLE.
- `mode`, in, 2: pattern select; sampled when `start` is accepted.
- `loop_en`, in, 1: repeat passes until reset.
- `err_inject`, in, 1: see Configuration.
- `sdram_init_done`, in, 1: controller initialisation complete.
- `wr_load`, out, 1: write-address reset to the controller.
- `rd_load`, out, 1: read-address reset to the controller.
- `sys_we`, out, 1: write-FIFO write enable.
- `sys_data_in`, out, DATA_W: write-FIFO data.
- `sys_rd`, out, 1: read-FIFO read enable.
- `sys_data_out`, in, DATA_W: read-FIFO data.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of each pass.
- `fail`, out, 1: sticky flag, set on any mismatch since the last accepted `start`.
- `err_cnt`, out, ERR_W: count of mismatches; saturates at all-ones.
- `pass_cnt`, out, 16: completed passes; wraps.
- `first_err_idx`, out, 16: word index of the first mismatch.
- `first_err_data`, out, DATA_W: data read at the first mismatch.

## Operation
- Pattern word k (k = 0..LEN-1):
  - mode 0: k truncated or zero-extended to DATA_W.
  - mode 1: LFSR. 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advanced once per word. Word 0 is the seed. The 16-bit value is replicated to fill DATA_W, LSBs aligned, then truncated.
  - mode 2: walking one, 1 << (k mod DATA_W).
  - mode 3: checkerboard. Even k gives all 0101 (…5555); odd k gives all 1010 (…AAAA).
- Each pass restarts the pattern from k=0, and from the seed in mode 1.
- FSM states:
  - IDLE: on `start`, clear `fail`, `err_cnt`, `pass_cnt`, `first_err_*`, latch `mode`, go to WAIT_INIT.
  - WAIT_INIT: stay until `sdram_init_done`=1, then go to LOAD.
  - LOAD: lasts 1 cycle, then go to WRITE.
  - WRITE: lasts LEN cycles. `sys_we`=1 and `sys_data_in`=word k in the k-th cycle. Then go to GAP.
  - GAP: lasts GAP_CYCLES cycles; 0 means skip directly to READ. Then go to READ.
  - READ: lasts LEN cycles with `sys_rd`=1. Then go to DRAIN.
  - DRAIN: lasts RD_LAT cycles. Then go to DONE.
  - DONE: lasts 1 cycle. `done`=1 and `pass_cnt`+1. Go to LOAD if `loop_en`, otherwise IDLE.
- Address-reset outputs:
  - `wr_load` and `rd_load` are 1 in IDLE, WAIT_INIT and LOAD.
  - Both are 0 from WRITE through DONE.
- Compare: the expected value comes from a second pattern generator advanced on each valid read beat, i.e. `sys_rd` delayed RD_LAT cycles.
- On a mismatch:
  - `err_cnt` increments unless saturated.
  - `fail` is set.
  - `first_err_idx` and `first_err_data` are captured only if `fail` was 0 beforehand.
- `sdram_init_done` falling after WAIT_INIT is ignored.
- `start` while `busy` is ignored.
- `sys_data_in` holds its last value when `sys_we`=0.

## Timing
- Reset values:
  - `wr_load`=1, `rd_load`=1.
  - `sys_we`=0, `sys_rd`=0, `sys_data_in`=0.
  - `busy`=0, `done`=0, `fail`=0.
  - All counters and captures are 0.
  - State is IDLE.
- All outputs are registered.
- `start` at cycle t with init already done:
  - WAIT_INIT at t+1, LOAD at t+2.
  - First `sys_we` at t+3.
- Pass length, LOAD to DONE inclusive: 1 + LEN + GAP_CYCLES + LEN + RD_LAT + 1 cycles.
- Read beat k is compared in cycle (k-th `sys_rd` cycle) + RD_LAT. `err_cnt` updates one cycle after that.
- Reset mid-run: all outputs return to reset values immediately; no partial pass is counted.

## Configuration
- `SDRAM_CHK_ERR_INJECT_EN` defined:
  - `err_inject` sampled high in IDLE on `start` arms injection for that run.
  - Armed injection inverts bit 0 of write word 0 of every pass.
- `SDRAM_CHK_ERR_INJECT_EN` undefined:
  - `err_inject` is ignored.
  - Written data is always the pure pattern.

## Test plan
- Default params, mode 0, ideal FIFO model (RD_LAT=1), `start` -> one `done` after 1+512+64+512+1+1 = 1091 cycles; `fail`=0, `err_cnt`=0, `pass_cnt`=1.
- Mode 1, DATA_W=16 -> `sys_data_in` sequence starts ACE1 and follows the LFSR; readback matches; `fail`=0.
- Model corrupts read word 100 to 16'hDEAD in mode 0 -> `err_cnt`=1, `first_err_idx`=100, `first_err_data`=16'hDEAD.
- `loop_en`=1, mode 3, 3 passes, then `rst` mid-READ -> `pass_cnt` reaches 3 before reset; after reset all outputs are at reset values.
- `sdram_init_done` held low for 200 cycles after `start` -> `sys_we` stays 0 and `wr_load`=1 until 2 cycles after init rises.
- Macro defined, `err_inject`=1, mode 0, LEN=16, `loop_en`=1 for 2 passes -> `err_cnt`=2, `first_err_idx`=0, `first_err_data`=16'h0001.
